fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Generates the 2-bit select codes that drive the ALU-operand 3:1 forwarding muxes in the EX stage, plus the load-use stall request for the decode stage. Keeps its own shadow pipeline of destination-register and control bits (EX, MEM and WB slots), fed each cycle by the instruction leaving ID. Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and produces the `sel` inputs consumed by the operand muxes.

## Interface
- No parameters; register index width is fixed at 5 bits.
- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_rs`  in  5  source register A of ID instruction
- `id_rt`  in  5  source register B of ID instruction
- `id_dst`  in  5  resolved destination register of ID instruction
- `id_regwrite`  in  1  ID instruction writes the register file
- `id_memread`  in  1  ID instruction is a load
- `flush`  in  1  squash the ID instruction (branch taken)
- `fwd_a_sel`  out  2  select for EX operand A mux
- `fwd_b_sel`  out  2  select for EX operand B mux
- `stall`  out  1  load-use hazard: hold PC and IF/ID, bubble into EX

## Operation
- Each of the 3 slots (EX, MEM, WB) holds: valid, rs, rt, dst, regwrite, memread. Only the EX slot uses rs/rt.
- Select encoding: 2'b00 register-file value, 2'b01 EX/MEM result, 2'b10 MEM/WB result. 2'b11 is never driven.
- `fwd_a_sel`: 2'b01 if EX.valid, MEM.valid, MEM.regwrite, MEM.dst != 0 and MEM.dst == EX.rs. Otherwise 2'b10 if the same conditions hold for the WB slot. Otherwise 2'b00. `fwd_b_sel` uses EX.rt in the same way.
- Priority: MEM beats WB when both match (youngest producer wins).
- Register 0 is never forwarded, regardless of regwrite.
- `stall` = id_valid & !flush & EX.valid & EX.memread & EX.regwrite & EX.dst != 0 & (EX.dst == id_rs | EX.dst == id_rt).
- Slot advance on every rising edge:
  - MEM <= EX; WB <= MEM.
  - EX <= ID fields with valid = id_valid, when `stall`=0 and `flush`=0.
  - EX <= bubble (valid=0, all other fields 0) when `stall`=1 or `flush`=1.
- There is no enable or freeze input: the shadow pipeline advances every cycle.

## Timing
- Reset (async assert, on `rst_n` low): all slots cleared to bubble, so `fwd_a_sel` = `fwd_b_sel` = 2'b00 and `stall` = 0 immediately.
- Reset deassertion is synchronized externally. The first edge after release loads normal ID data.
- Selects and `stall` are combinational from slot registers and ID inputs. They are valid in the same cycle the instruction occupies EX (zero-cycle latency, no output registers).
- A load-use pair costs exactly 1 stall cycle. On the next cycle the load sits in MEM and is not forwardable, so `stall` reasserts only if a new load-use pair forms.
- Flush and stall asserted together: the bubble is inserted once; `flush` wins for the ID contents.
- `rst_n` asserted mid-stall: `stall` drops immediately and all in-flight slot state is discarded.

## Configuration
- `FWD_STALL_CNT_EN` defined:
  - Adds output `stall_count` [15:0]. It increments on each edge where `stall`=1 and saturates at 16'hFFFF.
  - Reset value is 0.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

## Test plan
- **Back-to-back ALU dependency:** add $3 (dst 3), then sub rs=3 → while sub is in EX, `fwd_a_sel`=2'b01.
- **Distance-2 dependency:** producer dst=5, one unrelated instr, then consumer rt=5 → `fwd_b_sel`=2'b10 in the consumer's EX cycle.
- **Double producer:** two writers to $7 back-to-back, then consumer rs=7 → `fwd_a_sel`=2'b01 (MEM priority, not 2'b10).
- **$0 destination:** writer dst=0 with regwrite=1, consumer rs=0 → selects stay 2'b00 and `stall`=0.
- **Load-use:** lw dst=9, then ID rt=9 → `stall`=1 for exactly 1 cycle, EX holds a bubble. The next cycle gives `fwd_b_sel`=2'b10 for the consumer; with `FWD_STALL_CNT_EN`, `stall_count`=1.
- **Flush and reset:** flush during a load-use stall inserts a single bubble. Dropping `rst_n` mid-sequence → all outputs read 0 within the same cycle, without a clock edge.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding selects and load-use stall detection.
// Define FWD_STALL_CNT_EN to add a saturating 16-bit stall counter output (stall_count_o).
module fwd_hazard_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic [4:0]  id_dst_i,
    input  logic        id_regwrite_i,
    input  logic        id_memread_i,
    input  logic        flush_i,
    output logic [1:0]  fwd_a_sel_o,
    output logic [1:0]  fwd_b_sel_o,
`ifdef FWD_STALL_CNT_EN
    output logic        stall_o,
    output logic [15:0] stall_count_o
`else
    output logic        stall_o
`endif
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       regwrite;
        logic       memread;
    } ex_slot_t;

    // MEM and WB only ever act as producers, so their source fields are not kept.
    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       regwrite;
    } prod_slot_t;

    ex_slot_t   exSlot_q, exSlot_d;
    prod_slot_t memSlot_q, wbSlot_q;

    function automatic logic fwdHit(input prod_slot_t producer, input logic [4:0] src);
        return producer.valid && producer.regwrite &&
               (producer.dst != 5'd0) && (producer.dst == src);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exSlot_q  <= '0;
            memSlot_q <= '0;
            wbSlot_q  <= '0;
        end else begin
            exSlot_q  <= exSlot_d;
            memSlot_q <= '{valid: exSlot_q.valid, dst: exSlot_q.dst, regwrite: exSlot_q.regwrite};
            wbSlot_q  <= memSlot_q;
        end
    end

    always_comb begin
        stall_o = id_valid_i && !flush_i && exSlot_q.valid && exSlot_q.memread &&
                  exSlot_q.regwrite && (exSlot_q.dst != 5'd0) &&
                  ((exSlot_q.dst == id_rs_i) || (exSlot_q.dst == id_rt_i));
    end

    // A stalled or flushed ID instruction turns into a bubble in EX.
    always_comb begin
        exSlot_d = '0;
        if (!stall_o && !flush_i) begin
            exSlot_d.valid    = id_valid_i;
            exSlot_d.rs       = id_rs_i;
            exSlot_d.rt       = id_rt_i;
            exSlot_d.dst      = id_dst_i;
            exSlot_d.regwrite = id_regwrite_i;
            exSlot_d.memread  = id_memread_i;
        end
    end

    always_comb begin
        fwd_a_sel_o = 2'b00;
        fwd_b_sel_o = 2'b00;
        if (exSlot_q.valid) begin
            if (fwdHit(memSlot_q, exSlot_q.rs)) begin
                fwd_a_sel_o = 2'b01;
            end else if (fwdHit(wbSlot_q, exSlot_q.rs)) begin
                fwd_a_sel_o = 2'b10;
            end
            if (fwdHit(memSlot_q, exSlot_q.rt)) begin
                fwd_b_sel_o = 2'b01;
            end else if (fwdHit(wbSlot_q, exSlot_q.rt)) begin
                fwd_b_sel_o = 2'b10;
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [15:0] stallCount_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stallCount_q <= 16'h0000;
        end else if (stall_o && (stallCount_q != 16'hFFFF)) begin
            stallCount_q <= stallCount_q + 16'h0001;
        end
    end

    assign stall_count_o = stallCount_q;
`endif

endmodule
